apb_protocol_checker: RTL
=========================

Name: apb_protocol_checker

Overview:
- Synthesizable, parametrised APB protocol checker. It passively snoops one APB bus that has NUM_SEL select lines.
- Tracks the IDLE/SETUP/ACCESS phase and flags protocol violations as sticky flags, a one-cycle pulse and a saturating error count.
- Also counts completed transfers.
- Sits beside the APB slave/master ports of the Ethernet MAC. It makes the simulation-only protocol checks usable in silicon and emulation.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- NUM_SEL, 1, number of psel lines (slave channels).
- TIMEOUT, 16, consecutive ACCESS cycles with pready low before a timeout is flagged (>=2).
- CNT_W, 8, width of the error and transfer counters.

Ports:
- pclk_i  in  1  bus clock; all logic on rising edge.
- prstn_i  in  1  reset; synchronous and active-low.
- psel_i  in  NUM_SEL  slave selects.
- penable_i  in  1  APB enable.
- pwrite_i  in  1  APB direction.
- paddr_i  in  ADDR_W  APB address.
- pwdata_i  in  DATA_W  APB write data.
- pready_i  in  1  slave ready.
- chk_en_i  in  1  error recording enable.
- clr_i  in  1  clears sticky flags, error count and error address.
- err_o  out  6  sticky flags: [0] MULTI_SEL, [1] NO_SETUP, [2] NO_ACCESS, [3] UNSTABLE, [4] TIMEOUT, [5] ABORT.
- err_pulse_o  out  1  high for one cycle when any new error is recorded.
- err_cnt_o  out  CNT_W  number of error cycles, saturating.
- err_addr_o  out  ADDR_W  paddr_i captured at the most recent error.
- xfer_cnt_o  out  CNT_W  completed transfers, wrapping.
- busy_o  out  1  FSM is in SETUP or ACCESS.

Behaviour:
- Reset (prstn_i=0 at an edge): FSM goes to IDLE. All outputs and internal captures go to 0. Reset mid-transfer abandons the transfer with no error.
- All outputs are registered. An error detected from inputs sampled at edge N is visible after edge N.
- sel_any = |psel_i. MULTI_SEL is flagged in any state whenever more than one psel_i bit is high.
- IDLE:
  - sel_any & !penable_i -> SETUP. Capture psel_i, paddr_i, pwrite_i, pwdata_i.
  - sel_any & penable_i -> NO_SETUP error; stay in IDLE.
  - Otherwise stay in IDLE.
- SETUP:
  - sel_any & penable_i -> ACCESS, wait counter = 0. Apply the ACCESS checks and pready evaluation in this same cycle.
  - sel_any & !penable_i -> NO_ACCESS error; stay in SETUP and recapture.
  - !sel_any -> NO_ACCESS error; go to IDLE.
- ACCESS (checks every cycle):
  - !sel_any or !penable_i -> ABORT error; go to IDLE.
  - Otherwise compare psel_i, paddr_i, pwrite_i, and pwdata_i (pwdata only when the captured pwrite=1) against the captured values. Any mismatch -> UNSTABLE error, at most once per transfer.
  - pready_i=1 -> transfer complete, xfer_cnt_o+1 (wraps), go to IDLE. A back-to-back SETUP in the next cycle is handled from IDLE.
  - pready_i=0 -> wait+1. When wait reaches TIMEOUT, flag a TIMEOUT error once per transfer and stay in ACCESS. The wait counter saturates at TIMEOUT.
- Recording:
  - Errors are recorded only when chk_en_i=1; the FSM tracks the bus regardless.
  - On any recorded error: OR the new bits into err_o, err_pulse_o=1, err_cnt_o+1 (saturates at all-ones), err_addr_o=paddr_i.
  - Several errors in one cycle count as one increment.
- clr_i=1 clears err_o, err_cnt_o and err_addr_o. It does not clear xfer_cnt_o or the FSM.
- clr_i together with a new error: the new error wins. err_o = new bits only, err_cnt_o = 1, err_addr_o updated.
- NUM_SEL=1: MULTI_SEL can never fire.

Test Plan:
- Clean write to 0x00 with 0x2 data, pready high in the first ACCESS cycle -> xfer_cnt_o=1, err_o=0, busy_o high for 2 cycles.
- Read to 0x04 with pready low for 3 cycles and TIMEOUT=4, then TIMEOUT=3 -> first run: no error, xfer_cnt_o +1. Second run: err_o[4]=1, err_cnt_o=1, err_pulse_o for one cycle, transfer still completes.
- paddr changes 0x20->0x24 during the ACCESS wait -> err_o[3]=1, err_addr_o=0x24. Repeated changes in the same transfer give err_cnt_o=1.
- penable high with no SETUP cycle, then psel dropped in ACCESS -> err_o=6'b100010, err_cnt_o=2.
- NUM_SEL=4, psel=4'b0011 -> err_o[0]=1. With chk_en_i=0 the same stimulus leaves err_o=0.
- clr_i asserted in the same cycle as an ABORT with err_cnt_o=5 -> err_o=6'b100000, err_cnt_o=1. With CNT_W=2 and 5 errors -> err_cnt_o=3. prstn_i low mid-ACCESS -> all outputs 0 after the edge.

Source files
------------

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker. It snoops one APB bus and tracks the IDLE/SETUP/ACCESS
// phase. Protocol violations are recorded as sticky flags, a one-cycle pulse, a saturating
// error count and the address of the latest error. Completed transfers are also counted.
module apb_protocol_checker #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SEL = 1,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               pclk_i,
  input  logic               prstn_i,
  input  logic [NUM_SEL-1:0] psel_i,
  input  logic               penable_i,
  input  logic               pwrite_i,
  input  logic [ADDR_W-1:0]  paddr_i,
  input  logic [DATA_W-1:0]  pwdata_i,
  input  logic               pready_i,
  input  logic               chk_en_i,
  input  logic               clr_i,
  output logic [5:0]         err_o,
  output logic               err_pulse_o,
  output logic [CNT_W-1:0]   err_cnt_o,
  output logic [ADDR_W-1:0]  err_addr_o,
  output logic [CNT_W-1:0]   xfer_cnt_o,
  output logic               busy_o
);

  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT);

  localparam int unsigned ErrMultiSel = 0;
  localparam int unsigned ErrNoSetup  = 1;
  localparam int unsigned ErrNoAccess = 2;
  localparam int unsigned ErrUnstable = 3;
  localparam int unsigned ErrTimeout  = 4;
  localparam int unsigned ErrAbort    = 5;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e             state_q, state_d;
  logic [NUM_SEL-1:0] sel_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [WaitW-1:0]   wait_q, wait_d;
  logic               unst_q, unst_d;
  logic [5:0]         err_q, err_d;
  logic               pulse_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  eaddr_q, eaddr_d;
  logic [CNT_W-1:0]   xfer_q;
  logic               busy_q;

  logic               sel_any;
  logic               multi_sel;
  logic               mismatch;
  logic               capture;
  logic               access_eval;
  logic               xfer_done;
  logic               busy_d;
  logic [WaitW-1:0]   wait_base;
  logic               unst_base;
  logic [5:0]         err_det;
  logic [5:0]         err_rec;
  logic               err_hit;

  assign sel_any   = |psel_i;
  // More than one bit set: clearing the lowest set bit leaves something behind.
  assign multi_sel = |(psel_i & (psel_i - NUM_SEL'(1)));
  assign mismatch  = (psel_i != sel_q) || (paddr_i != addr_q) || (pwrite_i != write_q) ||
                     (write_q && (pwdata_i != wdata_q));

  // Phase tracking and violation detection from the inputs sampled at this edge.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    unst_d      = unst_q;
    capture     = 1'b0;
    access_eval = 1'b0;
    xfer_done   = 1'b0;
    err_det     = '0;
    err_det[ErrMultiSel] = multi_sel;
    // The first ACCESS cycle is evaluated from SETUP, so it starts from fresh per-transfer state.
    wait_base = (state_q == StSetup) ? '0 : wait_q;
    unst_base = (state_q == StSetup) ? 1'b0 : unst_q;

    unique case (state_q)
      StIdle: begin
        if (sel_any && !penable_i) begin
          state_d = StSetup;
          capture = 1'b1;
        end else if (sel_any && penable_i) begin
          err_det[ErrNoSetup] = 1'b1;
        end
      end
      StSetup: begin
        if (!sel_any) begin
          err_det[ErrNoAccess] = 1'b1;
          state_d = StIdle;
        end else if (!penable_i) begin
          err_det[ErrNoAccess] = 1'b1;
          capture = 1'b1;
        end else begin
          access_eval = 1'b1;
        end
      end
      StAccess: begin
        if (!sel_any || !penable_i) begin
          err_det[ErrAbort] = 1'b1;
          state_d = StIdle;
        end else begin
          access_eval = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      wait_d = '0;
      unst_d = 1'b0;
    end

    if (access_eval) begin
      if (mismatch && !unst_base) begin
        err_det[ErrUnstable] = 1'b1;
      end
      unst_d = unst_base | mismatch;
      if (pready_i) begin
        xfer_done = 1'b1;
        state_d   = StIdle;
        wait_d    = '0;
      end else begin
        state_d = StAccess;
        if (wait_base != WaitMax) begin
          wait_d = wait_base + WaitW'(1);
          // Fires only on the step that reaches the limit, so once per transfer.
          if (wait_base + WaitW'(1) == WaitMax) begin
            err_det[ErrTimeout] = 1'b1;
          end
        end else begin
          wait_d = wait_base;
        end
      end
    end

    // Busy covers every sampled SETUP/ACCESS cycle, including the completing one.
    busy_d = (state_d != StIdle) || xfer_done;
  end

  // Error recording: a new error overrides a simultaneous clear.
  always_comb begin
    err_rec = chk_en_i ? err_det : '0;
    err_hit = |err_rec;
    err_d   = err_q;
    cnt_d   = cnt_q;
    eaddr_d = eaddr_q;
    if (err_hit) begin
      err_d   = (clr_i ? '0 : err_q) | err_rec;
      cnt_d   = clr_i ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
      eaddr_d = paddr_i;
    end else if (clr_i) begin
      err_d   = '0;
      cnt_d   = '0;
      eaddr_d = '0;
    end
  end

  // State, captures and registered outputs with synchronous active-low reset.
  always_ff @(posedge pclk_i) begin
    if (!prstn_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wait_q  <= '0;
      unst_q  <= 1'b0;
      err_q   <= '0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      eaddr_q <= '0;
      xfer_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      unst_q  <= unst_d;
      if (capture) begin
        sel_q   <= psel_i;
        addr_q  <= paddr_i;
        write_q <= pwrite_i;
        wdata_q <= pwdata_i;
      end
      err_q   <= err_d;
      pulse_q <= err_hit;
      cnt_q   <= cnt_d;
      eaddr_q <= eaddr_d;
      if (xfer_done) begin
        xfer_q <= xfer_q + CNT_W'(1);
      end
      busy_q  <= busy_d;
    end
  end

  assign err_o       = err_q;
  assign err_pulse_o = pulse_q;
  assign err_cnt_o   = cnt_q;
  assign err_addr_o  = eaddr_q;
  assign xfer_cnt_o  = xfer_q;
  assign busy_o      = busy_q;

endmodule
